// File: rtl/adc_iq_capture.sv
// Triggered I/Q snapshot capture into a FWFT FIFO, drained as {I,Q} words.
// Define ADC_CAPTURE_THRESH_TRIG_EN to add an |I| >= threshold trigger.
module adc_iq_capture #(
  parameter int FIFO_AW = 10,
  parameter int LEN_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      adc_i,
  input  logic [15:0]      adc_q,
  input  logic             adc_valid,
  input  logic             arm,
  input  logic             trig_ext,
  input  logic [LEN_W-1:0] capture_len,
  input  logic [15:0]      threshold,
  output logic [31:0]      m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             busy,
  output logic             armed,
  output logic             done,
  output logic             overflow
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPT,
    S_FLUSH
  } state_e;

  state_e state_q, state_d;

  logic [15:0]      si_q, sq_q;
  logic             sv_q, st_q;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, cnt_nxt;
  logic             ovf_q, ovf_d;
  logic [FIFO_AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [FIFO_AW:0]   occ_q, occ_d;
  logic [32:0]      mem_q [DEPTH];

  logic full, empty, trig, push_req, push, pop, wlast;

`ifdef ADC_CAPTURE_THRESH_TRIG_EN
  logic [15:0] abs_i;

  // |-32768| has no 16-bit signed magnitude, so it saturates.
  always_comb begin
    abs_i = si_q;
    if (si_q[15]) begin
      if (si_q == 16'h8000) abs_i = 16'h7fff;
      else                  abs_i = ~si_q + 16'd1;
    end
  end

  assign trig = st_q | (abs_i >= threshold);
`else
  logic unused_threshold;
  assign unused_threshold = ^threshold;
  assign trig = st_q;
`endif

  assign full  = occ_q == (FIFO_AW+1)'(DEPTH);
  assign empty = occ_q == '0;
  assign pop   = !empty && m_ready;

  always_comb begin
    cnt_nxt  = (state_q == S_ARMED) ? LEN_W'(1) : cnt_q + LEN_W'(1);
    wlast    = cnt_nxt == len_q;
    push_req = sv_q && ((state_q == S_ARMED && trig) || state_q == S_CAPT);
    push     = push_req && !full;
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (arm && capture_len != '0) begin
          state_d = S_ARMED;
          len_d   = capture_len;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      S_ARMED, S_CAPT: begin
        if (push_req) begin
          if (full) begin
            ovf_d   = 1'b1;
            state_d = S_FLUSH;
          end else begin
            cnt_d   = cnt_nxt;
            state_d = wlast ? S_FLUSH : S_CAPT;
          end
        end
      end
      S_FLUSH: begin
        if (empty) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_d  = wr_q + FIFO_AW'(push);
    rd_d  = rd_q + FIFO_AW'(pop);
    occ_d = occ_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      si_q    <= '0;
      sq_q    <= '0;
      sv_q    <= 1'b0;
      st_q    <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      si_q    <= adc_i;
      sq_q    <= adc_q;
      sv_q    <= adc_valid;
      st_q    <= trig_ext;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      occ_q   <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {wlast, si_q, sq_q};
  end

  assign m_valid  = !empty;
  assign m_data   = empty ? 32'd0 : mem_q[rd_q][31:0];
  assign m_last   = !empty && mem_q[rd_q][32];
  assign busy     = state_q != S_IDLE;
  assign armed    = state_q == S_ARMED;
  assign done     = state_q == S_FLUSH && empty;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_adc_iq_capture.sv
// Randomized directed bench for adc_iq_capture (8-word FIFO build).
// Expected words come from a queue model of the capture rules.
module tb_adc_iq_capture;

  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] adc_i = '0;
  logic [15:0] adc_q = '0;
  logic        adc_valid = 1'b0;
  logic        arm = 1'b0;
  logic        trig_ext = 1'b0;
  logic [15:0] capture_len = '0;
  logic [15:0] threshold = 16'hffff;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_last;
  logic        busy;
  logic        armed;
  logic        done;
  logic        overflow;

  always #5 clk = ~clk;

  adc_iq_capture #(.FIFO_AW(AW), .LEN_W(16)) dut (
    .clk(clk), .rst(rst),
    .adc_i(adc_i), .adc_q(adc_q), .adc_valid(adc_valid),
    .arm(arm), .trig_ext(trig_ext),
    .capture_len(capture_len), .threshold(threshold),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .busy(busy), .armed(armed),
    .done(done), .overflow(overflow)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_w[$];
  logic        exp_l[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(string tag);
    chk({tag, "_mvalid"}, 32'(m_valid), 0);
    chk({tag, "_mdata"}, m_data, 0);
    chk({tag, "_mlast"}, 32'(m_last), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_armed"}, 32'(armed), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
  endtask

  // Starts and ends on a negedge. hold: m_ready low until all samples sent.
  task automatic run_capture(int len, int pre, int rp, int vg, bit hold);
    int  total;
    int  sent;
    int  pushed;
    int  last_pop;
    int  ndone;
    bit  held;
    bit  ovf_exp;
    logic [31:0] held_d;
    total    = pre + len;
    sent     = 0;
    pushed   = 0;
    last_pop = -100;
    ndone    = 0;
    held     = 1'b0;
    held_d   = '0;
    ovf_exp  = hold && (len > DEPTH);
    arm = 1'b1;
    capture_len = 16'(len);
    @(negedge clk);
    arm = 1'b0;
    chk("arm_armed", 32'(armed), 1);
    chk("arm_busy", 32'(busy), 1);
    chk("arm_ovf_clr", 32'(overflow), 0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (sent < total && (cyc % vg) == 0) begin
        adc_valid = 1'b1;
        adc_i     = 16'($urandom);
        adc_q     = 16'($urandom);
        trig_ext  = (sent == pre) ||
                    (sent > pre && $urandom_range(0, 1) == 1);
        if (sent >= pre && (!hold || pushed < DEPTH)) begin
          exp_w.push_back({adc_i, adc_q});
          exp_l.push_back(sent == total - 1);
          pushed++;
        end
        sent++;
      end else begin
        adc_valid = 1'b0;
        trig_ext  = 1'b0;
      end
      m_ready = hold ? (sent >= total) : ((cyc % rp) == 0);
      if (held) begin
        chk("stall_valid", 32'(m_valid), 1);
        chk("stall_data", m_data, held_d);
      end
      if (m_valid && m_ready) begin
        if (exp_w.size() == 0) begin
          chk("extra_word", 32'(m_valid), 0);
        end else begin
          chk("word", m_data, exp_w.pop_front());
          chk("last", 32'(m_last), 32'(exp_l.pop_front()));
        end
        last_pop = cyc;
      end
      held   = m_valid && !m_ready;
      held_d = m_data;
      if (done) begin
        ndone++;
        chk("done_empty", exp_w.size(), 0);
        chk("done_lat", cyc - last_pop, 1);
        chk("done_ovf", 32'(overflow), 32'(ovf_exp));
        break;
      end
      @(negedge clk);
    end
    chk("done_seen", ndone, 1);
    adc_valid = 1'b0;
    trig_ext  = 1'b0;
    m_ready   = 1'b0;
    @(negedge clk);
    chk("post_busy", 32'(busy), 0);
    chk("post_done", 32'(done), 0);
    chk("post_valid", 32'(m_valid), 0);
    exp_w.delete();
    exp_l.delete();
  endtask

  initial begin
    int len;
    int rp;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_idle("rst0");

    run_capture(4, 1, 1, 1, 1'b0);
    run_capture(1, 0, 1, 1, 1'b0);

    arm = 1'b1;
    capture_len = 16'd0;
    @(negedge clk);
    arm = 1'b0;
    chk("len0_busy", 32'(busy), 0);
    chk("len0_armed", 32'(armed), 0);

    run_capture(20, 2, 1, 1, 1'b1);
    run_capture(16, 0, 3, 4, 1'b0);

    for (int k = 0; k < 5; k++) begin
      len = $urandom_range(1, 30);
      rp  = $urandom_range(1, 3);
      run_capture(len, $urandom_range(0, 3), rp,
                  (rp == 1) ? $urandom_range(1, 3) : 4, 1'b0);
    end
    run_capture($urandom_range(1, DEPTH), $urandom_range(0, 2),
                1, 1, 1'b1);

    threshold = 16'h4000;
    arm = 1'b1;
    capture_len = 16'd2;
    @(negedge clk);
    arm = 1'b0;
    adc_valid = 1'b1;
    adc_i = 16'h3fff;
    adc_q = 16'h1234;
    @(negedge clk);
    adc_i = 16'hc000;
    @(negedge clk);
    adc_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
`ifdef ADC_CAPTURE_THRESH_TRIG_EN
    chk("thr_armed", 32'(armed), 0);
    chk("thr_valid", 32'(m_valid), 1);
    chk("thr_word", m_data, 32'hc0001234);
`else
    chk("thr_armed", 32'(armed), 1);
    chk("thr_valid", 32'(m_valid), 0);
`endif
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    threshold = 16'hffff;
    chk_idle("rst_mid");

    run_capture(5, 1, 1, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
